// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 retire stage: flag bit positions, the
// canonical quiet NaN, and the result/flags record carried through the FIFO.
package fma16_pkg;

   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [15:0] QNAN16 = 16'h7E00;

   typedef struct packed {
      logic [15:0] result;
      logic [3:0]  flags;
   } fma16_res_t;

endpackage

// File: rtl/fma16_res_fifo.sv
// Small synchronous FIFO holding retired fma16 entries. The occupancy count
// is kept explicitly so full/empty need no extra pointer wrap bit.
module fma16_res_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  count_q, count_d;

   assign full    = (count_q == FULL_OCC);
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; push/pop arrive pre-qualified.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared on reset so the head reads as zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fma16_retire.sv
// Retire stage behind the combinational fma16 datapath: queues each result
// with its flags and tag, and keeps sticky fflags, a NaN-sanity flag and a
// retired-op counter for the CSR block.
module fma16_retire
   import fma16_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_result,
   input  logic [3:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       fflags,
   input  logic             fflags_clr,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             nan_err
);

   localparam int DATA_W = $bits(fma16_res_t) + TAG_W;

   logic              full, empty, accept, issue;
   fma16_res_t        res_in, res_out;
   logic [TAG_W-1:0]  tag_out;
   logic [DATA_W-1:0] wr_data, rd_data;
   logic [3:0]        fflags_q, fflags_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic              nan_err_q, nan_err_d;

   assign accept    = in_valid && !full;
   assign issue     = !empty && out_ready;
   assign in_ready  = !full;
   assign out_valid = !empty;

   assign res_in.result = in_result;
   assign res_in.flags  = in_flags;
   assign wr_data       = {res_in, in_tag};
   assign {res_out, tag_out} = rd_data;

   assign out_result = res_out.result;
   assign out_flags  = res_out.flags;
   assign out_tag    = tag_out;
   assign fflags     = fflags_q;
   assign retire_cnt = retire_cnt_q;
   assign nan_err    = nan_err_q;

   fma16_res_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (accept),
      .wr_data (wr_data),
      .pop     (issue),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   // Sticky status; a clear and an accept on the same edge keep the new op's flags.
   always_comb begin
      fflags_d     = (fflags_clr ? 4'b0000 : fflags_q) | (accept ? in_flags : 4'b0000);
      retire_cnt_d = issue ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
      nan_err_d    = nan_err_q;
      if (accept && in_flags[FLAG_NV] && (in_result != QNAN16)) begin
         nan_err_d = 1'b1;
      end
   end

   // Status registers; nan_err is only ever cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags_q     <= '0;
         retire_cnt_q <= '0;
         nan_err_q    <= 1'b0;
      end else begin
         fflags_q     <= fflags_d;
         retire_cnt_q <= retire_cnt_d;
         nan_err_q    <= nan_err_d;
      end
   end

endmodule

// File: tb/tb_fma16_retire.sv
// Directed and random-stress bench for fma16_retire (DEPTH=2, TAG_W=4, CNT_W=4).
module tb_fma16_retire;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [3:0]  in_flags;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  out_tag;
   logic [3:0]  fflags;
   logic        fflags_clr;
   logic [3:0]  retire_cnt;
   logic        nan_err;

   int n_checks = 0;
   int n_errors = 0;

   fma16_retire #(.DEPTH(2), .TAG_W(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_flags   (in_flags),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .fflags     (fflags),
      .fflags_clr (fflags_clr),
      .retire_cnt (retire_cnt),
      .nan_err    (nan_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f, input logic [3:0] t);
      in_valid  = v;
      in_result = r;
      in_flags  = f;
      in_tag    = t;
   endtask

   task automatic do_reset();
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      out_ready  = 1'b0;
      fflags_clr = 1'b0;
      rst_n      = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      fflags_clr = 1'b0;
      out_ready  = 1'b1;
      drive(1'b1, 16'h3C00, 4'hF, 4'h5);
      repeat (3) tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (fflags !== 4'h0) begin n_errors++; $display("FAIL reset_fflags got=%h exp=0", fflags); end
      n_checks++; if (retire_cnt !== 4'h0) begin n_errors++; $display("FAIL reset_retire_cnt got=%0d exp=0", retire_cnt); end
      n_checks++; if (nan_err !== 1'b0) begin n_errors++; $display("FAIL reset_nan_err got=%b exp=0", nan_err); end
      n_checks++; if ({out_result, out_flags, out_tag} !== 24'h0) begin n_errors++; $display("FAIL reset_out_data got=%h exp=0", {out_result, out_flags, out_tag}); end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      rst_n = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_in_order();
      out_ready = 1'b1;
      drive(1'b1, 16'h3C00, 4'b0000, 4'h1);
      tick();
      n_checks++; if ({out_valid, out_result, out_flags, out_tag} !== {1'b1, 16'h3C00, 4'b0000, 4'h1}) begin n_errors++; $display("FAIL order_first got=%b/%h/%b/%h exp=1/3c00/0000/1", out_valid, out_result, out_flags, out_tag); end
      drive(1'b1, 16'h7E00, 4'b1000, 4'h2);
      tick();
      n_checks++; if ({out_valid, out_result, out_flags, out_tag} !== {1'b1, 16'h7E00, 4'b1000, 4'h2}) begin n_errors++; $display("FAIL order_second got=%b/%h/%b/%h exp=1/7e00/1000/2", out_valid, out_result, out_flags, out_tag); end
      n_checks++; if (retire_cnt !== 4'd1) begin n_errors++; $display("FAIL order_cnt1 got=%0d exp=1", retire_cnt); end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL order_drained got=%b exp=0", out_valid); end
      n_checks++; if (retire_cnt !== 4'd2) begin n_errors++; $display("FAIL order_cnt2 got=%0d exp=2", retire_cnt); end
      n_checks++; if (fflags !== 4'b1000) begin n_errors++; $display("FAIL order_fflags got=%b exp=1000", fflags); end
      n_checks++; if (nan_err !== 1'b0) begin n_errors++; $display("FAIL order_nan_err got=%b exp=0", nan_err); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 16'hA001, 4'b0001, 4'hA);
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
      drive(1'b1, 16'hB002, 4'b0010, 4'hB);
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full got=%b exp=0", in_ready); end
      drive(1'b1, 16'hC003, 4'b0000, 4'hC);
      tick();
      tick();
      n_checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 16'hA001, 4'hA}) begin n_errors++; $display("FAIL bp_head_hold got=%b/%h/%h exp=1/a001/a", out_valid, out_result, out_tag); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      tick();
      n_checks++; if ({out_result, out_tag, in_ready} !== {16'hB002, 4'hB, 1'b1}) begin n_errors++; $display("FAIL bp_release1 got=%h/%h/%b exp=b002/b/1", out_result, out_tag, in_ready); end
      tick();
      n_checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 16'hC003, 4'hC}) begin n_errors++; $display("FAIL bp_release2 got=%b/%h/%h exp=1/c003/c", out_valid, out_result, out_tag); end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
      n_checks++; if (retire_cnt !== 4'd5) begin n_errors++; $display("FAIL bp_cnt got=%0d exp=5", retire_cnt); end
      n_checks++; if (fflags !== 4'b1011) begin n_errors++; $display("FAIL bp_fflags got=%b exp=1011", fflags); end
      tick();
      n_checks++; if (retire_cnt !== 4'd5) begin n_errors++; $display("FAIL empty_ready_cnt got=%0d exp=5", retire_cnt); end
   endtask

   task automatic test_fflags_clr();
      out_ready  = 1'b1;
      fflags_clr = 1'b1;
      tick();
      n_checks++; if (fflags !== 4'b0000) begin n_errors++; $display("FAIL clr_plain got=%b exp=0000", fflags); end
      fflags_clr = 1'b0;
      drive(1'b1, 16'h3C00, 4'b0001, 4'h3);
      tick();
      n_checks++; if (fflags !== 4'b0001) begin n_errors++; $display("FAIL clr_nx got=%b exp=0001", fflags); end
      fflags_clr = 1'b1;
      drive(1'b1, 16'h7BFF, 4'b0100, 4'h4);
      tick();
      n_checks++; if (fflags !== 4'b0100) begin n_errors++; $display("FAIL clr_and_accept got=%b exp=0100", fflags); end
      fflags_clr = 1'b0;
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      tick();
      n_checks++; if (retire_cnt !== 4'd7) begin n_errors++; $display("FAIL clr_cnt got=%0d exp=7", retire_cnt); end
   endtask

   task automatic test_nan_err();
      out_ready = 1'b1;
      drive(1'b1, 16'h7C00, 4'b1000, 4'h6);
      tick();
      n_checks++; if (nan_err !== 1'b1) begin n_errors++; $display("FAIL nan_set got=%b exp=1", nan_err); end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      n_checks++; if (nan_err !== 1'b1) begin n_errors++; $display("FAIL nan_sticky got=%b exp=1", nan_err); end
      n_checks++; if (fflags !== 4'b0000) begin n_errors++; $display("FAIL nan_fflags_cleared got=%b exp=0000", fflags); end
      n_checks++; if (retire_cnt !== 4'd8) begin n_errors++; $display("FAIL nan_cnt got=%0d exp=8", retire_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 16'h1111, 4'b0010, 4'h7);
      tick();
      drive(1'b1, 16'h2222, 4'b0010, 4'h8);
      tick();
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      n_checks++; if ({out_valid, in_ready, fflags, retire_cnt, nan_err} !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b0}) begin n_errors++; $display("FAIL mid_reset_async got=%b/%b/%b/%0d/%b exp=0/1/0000/0/0", out_valid, in_ready, fflags, retire_cnt, nan_err); end
      n_checks++; if ({out_result, out_flags, out_tag} !== 24'h0) begin n_errors++; $display("FAIL mid_reset_data got=%h exp=0", {out_result, out_flags, out_tag}); end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      n_checks++; if ({out_valid, retire_cnt} !== {1'b0, 4'h0}) begin n_errors++; $display("FAIL mid_reset_discard got=%b/%0d exp=0/0", out_valid, retire_cnt); end
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 16'(16'h4000 + i), 4'h0, 4'(i));
         tick();
      end
      n_checks++; if (retire_cnt !== 4'd0) begin n_errors++; $display("FAIL wrap_16 got=%0d exp=0", retire_cnt); end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      tick();
      n_checks++; if (retire_cnt !== 4'd1) begin n_errors++; $display("FAIL wrap_17 got=%0d exp=1", retire_cnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_random();
      logic [23:0] q[$];
      logic [3:0]  m_fflags;
      logic [3:0]  m_cnt;
      logic        m_nan;
      logic        acc, iss;
      logic [15:0] r;
      logic [3:0]  f;
      do_reset();
      m_fflags = 4'h0;
      m_cnt    = 4'h0;
      m_nan    = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         n_checks++; if (out_valid !== (q.size() > 0)) begin n_errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0); end
         n_checks++; if (in_ready !== (q.size() < 2)) begin n_errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            n_checks++; if ({out_result, out_flags, out_tag} !== q[0]) begin n_errors++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, {out_result, out_flags, out_tag}, q[0]); end
         end
         n_checks++; if ({fflags, retire_cnt, nan_err} !== {m_fflags, m_cnt, m_nan}) begin n_errors++; $display("FAIL rnd_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, fflags, retire_cnt, nan_err, m_fflags, m_cnt, m_nan); end
         case ($urandom_range(0, 3))
            0:       r = 16'h7E00;
            1:       r = 16'h3C00;
            default: r = 16'($urandom);
         endcase
         f = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(4'($urandom) & 4'b0111);
         drive($urandom_range(0, 2) != 0, r, f, 4'(cyc));
         out_ready  = ($urandom_range(0, 2) != 0);
         fflags_clr = ($urandom_range(0, 15) == 0);
         acc = in_valid && (q.size() < 2);
         iss = out_ready && (q.size() > 0);
         tick();
         if (iss) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 4'd1;
         end
         if (acc) begin
            q.push_back({r, f, 4'(cyc)});
            if (f[3] && r != 16'h7E00) m_nan = 1'b1;
         end
         m_fflags = (fflags_clr ? 4'h0 : m_fflags) | (acc ? f : 4'h0);
      end
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      fflags_clr = 1'b0;
      out_ready  = 1'b1;
      while (q.size() > 0) begin
         n_checks++; if ({out_valid, out_result, out_flags, out_tag} !== {1'b1, q[0]}) begin n_errors++; $display("FAIL rnd_drain got=%b/%h exp=1/%h", out_valid, {out_result, out_flags, out_tag}, q[0]); end
         tick();
         void'(q.pop_front());
         m_cnt = m_cnt + 4'd1;
      end
      n_checks++; if ({out_valid, retire_cnt} !== {1'b0, m_cnt}) begin n_errors++; $display("FAIL rnd_final got=%b/%0d exp=0/%0d", out_valid, retire_cnt, m_cnt); end
   endtask

   initial begin
      rst_n      = 1'b0;
      out_ready  = 1'b0;
      fflags_clr = 1'b0;
      drive(1'b0, 16'h0, 4'h0, 4'h0);
      test_reset();
      test_in_order();
      test_backpressure();
      test_fflags_clr();
      test_nan_err();
      test_reset_mid();
      test_cnt_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
